// File: rtl/pattern_serializer.sv
// pattern_serializer: shifts a latched pattern word out MSB-first on a
// single serial line, one bit per tick, repeated a programmable number of
// times. An overlapping "101" tracker watches only the emitted bits and
// keeps a saturating hit count for comparison against the detector.
module pattern_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(WIDTH + 1),
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic [CNT_W-1:0] rep,
  output logic             ready,
  output logic             busy,
  output logic             x,
  output logic             x_strobe,
  output logic             done,
  output logic [CNT_W-1:0] hits
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_FIN} state_t;
  typedef enum logic [1:0] {T0, T1, T2, T3} trk_t;

  state_t           state_q, state_d;
  trk_t             trk_q, trk_d, trk_next;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] repleft_q, repleft_d;
  logic             x_q, x_d;
  logic             strobe_q, strobe_d;
  logic [CNT_W-1:0] hits_q, hits_d;

  logic [LW-1:0]    len_clamped;
  logic             bit_cur;
  logic             trk_hit;

  // Lengths beyond the pattern register are treated as a full-width pattern.
  assign len_clamped = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;

  // The bit currently selected for transmission.
  assign bit_cur = pat_q[idx_q];

  // Overlapping "101" tracker step for the bit about to be emitted.
  always_comb begin
    trk_next = trk_q;
    trk_hit  = 1'b0;
    case (trk_q)
      T0: trk_next = bit_cur ? T1 : T0;
      T1: trk_next = bit_cur ? T1 : T2;
      T2: begin
        trk_next = bit_cur ? T3 : T0;
        trk_hit  = bit_cur;
      end
      T3: trk_next = bit_cur ? T1 : T2;
      default: trk_next = T0;
    endcase
  end

  // Frame sequencing: accept, shift bits on ticks, hold the last bit, finish.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    repleft_d = repleft_q;
    x_d       = x_q;
    strobe_d  = 1'b0;
    hits_d    = hits_q;
    trk_d     = trk_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d     = pattern;
          len_d     = len_clamped;
          repleft_d = rep;
          hits_d    = '0;
          trk_d     = T0;
          if ((len_clamped == '0) || (rep == '0)) begin
            state_d = S_FIN;
          end else begin
            idx_d   = IW'(len_clamped - LW'(1));
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (tick) begin
          x_d      = bit_cur;
          strobe_d = 1'b1;
          trk_d    = trk_next;
          if (trk_hit && (hits_q != '1)) begin
            hits_d = hits_q + CNT_W'(1);
          end
          if (idx_q != '0) begin
            idx_d = idx_q - IW'(1);
          end else if (repleft_q > CNT_W'(1)) begin
            repleft_d = repleft_q - CNT_W'(1);
            idx_d     = IW'(len_q - LW'(1));
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Last bit stays on the line until the next tick closes its period.
        if (tick) begin
          x_d     = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      trk_q     <= T0;
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      repleft_q <= '0;
      x_q       <= 1'b0;
      strobe_q  <= 1'b0;
      hits_q    <= '0;
    end else begin
      state_q   <= state_d;
      trk_q     <= trk_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      repleft_q <= repleft_d;
      x_q       <= x_d;
      strobe_q  <= strobe_d;
      hits_q    <= hits_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_SHIFT) || (state_q == S_DRAIN);
  assign done     = (state_q == S_FIN);
  assign x        = x_q;
  assign x_strobe = strobe_q;
  assign hits     = hits_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: frames with hand-computed bit
// counts, latencies and hit counts, plus busy-start and mid-frame reset.
module tb_pattern_serializer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [7:0] rep;
  logic       ready;
  logic       busy;
  logic       x;
  logic       x_strobe;
  logic       done;
  logic [7:0] hits;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_edge = 0;
  logic bits[$];
  int   scyc[$];

  pattern_serializer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .pattern(pattern), .len(len), .rep(rep),
    .ready(ready), .busy(busy), .x(x), .x_strobe(x_strobe),
    .done(done), .hits(hits)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after edge N (and until the next one) cyc holds N.
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: records each strobed bit with the edge that
  // registered it, and the edge at which each done pulse is sampled.
  always @(negedge clk) begin
    if (x_strobe) begin
      bits.push_back(x);
      scyc.push_back(cyc);
    end
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_edge <= cyc + 1;
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] p,
                           input logic [3:0] l, input logic [7:0] r,
                           input int div, input int poke,
                           input int exp_bits, input int exp_first,
                           input int exp_done, input int exp_hits);
    int base_bits, base_done, acc, n, se, ge, k, lc, nb;
    base_bits = bits.size();
    base_done = done_cnt;
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_ready_pre"}, int'(ready), 1);
    pattern = p; len = l; rep = r; start = 1'b1; tick = 1'b1;
    acc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    pattern = ~p; len = 4'd1; rep = 8'd7;
    check_val({tag, "_ready_acc"}, int'(ready), 0);
    check_val({tag, "_busy_acc"}, int'(busy), (exp_bits > 0) ? 1 : 0);
    n = 0;
    while (done_cnt == base_done && n < 5000) begin
      tick = (((n + 1) % div) == 0);
      if (n == poke) begin
        start = 1'b1; pattern = 8'hFF; len = 4'd8; rep = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    tick = 1'b1;
    if (done_cnt == base_done) check_val({tag, "_done_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    nb = bits.size() - base_bits;
    check_val({tag, "_nbits"}, nb, exp_bits);
    lc = (l > 8) ? 8 : int'(l);
    se = 0; k = 0;
    for (int rr = 0; rr < int'(r); rr++) begin
      for (int i = lc - 1; i >= 0; i--) begin
        if (k < nb) begin
          if (bits[base_bits + k] !== p[i]) se++;
        end
        k++;
      end
    end
    check_val({tag, "_stream_errs"}, se, 0);
    if (exp_bits > 0) check_val({tag, "_first_lat"}, scyc[base_bits] - acc, exp_first);
    if (nb > 1) begin
      ge = 0;
      for (int i = 1; i < nb; i++)
        if (scyc[base_bits + i] - scyc[base_bits + i - 1] != div) ge++;
      check_val({tag, "_spacing_errs"}, ge, 0);
    end
    check_val({tag, "_done_cnt"}, done_cnt - base_done, 1);
    check_val({tag, "_done_lat"}, done_edge - acc, exp_done);
    check_val({tag, "_hits"}, int'(hits), exp_hits);
    check_val({tag, "_ready_post"}, int'(ready), 1);
    check_val({tag, "_x_idle"}, int'(x), 0);
    $display("frame %s: bits=%0d hits=%0d done_lat=%0d", tag, nb, hits, done_edge - acc);
  endtask

  initial begin
    int base_bits, base_done, n;
    reset = 1'b1; start = 1'b0; tick = 1'b0;
    pattern = '0; len = '0; rep = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", int'(ready), 1);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_x", int'(x), 0);
    check_val("rst_strobe", int'(x_strobe), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_hits", int'(hits), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    //        tag        pat    len  rep   div poke bits first done hits
    run_frame("h05_l3",  8'h05, 3,  8'd1,   1, -1,  3,   1,   5,    1);
    run_frame("rep0",    8'h05, 3,  8'd0,   1, -1,  0,   0,   1,    0);
    run_frame("h02_r4",  8'h02, 2,  8'd4,   1, -1,  8,   1,  10,    3);
    run_frame("len0",    8'h00, 0,  8'd5,   1, -1,  0,   0,   1,    0);
    run_frame("hFF_r2",  8'hFF, 8,  8'd2,   1, -1, 16,   1,  18,    0);
    run_frame("tick4",   8'h05, 3,  8'd1,   4, -1,  3,   4,  17,    1);
    run_frame("poke",    8'h05, 3,  8'd2,   1,  2,  6,   1,   8,    2);
    run_frame("clamp",   8'hA5, 15, 8'd1,   1, -1,  8,   1,  10,    2);
    run_frame("sat55",   8'h55, 8,  8'd100, 1, -1, 800,  1, 802,  255);
    run_frame("r255",    8'h05, 3,  8'd255, 1, -1, 765,  1, 767,  255);

    // Mid-frame asynchronous reset: everything clears at once, no done.
    base_bits = bits.size();
    base_done = done_cnt;
    pattern = 8'hA5; len = 4'd8; rep = 8'd1; tick = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while ((bits.size() - base_bits) < 3 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_val("mid_busy", int'(busy), 1);
    check_val("mid_hits", int'(hits), 1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_x", int'(x), 0);
    check_val("arst_busy", int'(busy), 0);
    check_val("arst_hits", int'(hits), 0);
    check_val("arst_ready", int'(ready), 1);
    check_val("arst_strobe", int'(x_strobe), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_val("arst_no_done", done_cnt - base_done, 0);
    check_val("arst_idle", int'(ready), 1);
    $display("frame reset_mid: bits_before_reset=%0d", bits.size() - base_bits);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
